coin_collector: RTL and testbench
=================================

# coin_collector

Credit-intake stage that sits directly upstream of the game credit counter. Accepts coin events from the coin mechanism, accumulates them into a pending amount, and on player commit (or auto-commit timeout) delivers the total as a one-cycle `money`/`set` pair that the counter adds to its remaining credit. Cancel returns the pending amount via a refund pulse instead.

## Interface
- `TIMEOUT_CYC`, default 1000: idle cycles in COLLECT before auto-commit; legal range 2..65535.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset: asynchronous assert, active-low.
- `coin_vld`  in  1  one-cycle coin event.
- `coin_type`  in  2  coin value: 00=1, 01=5, 10=10, 11=invalid (ignored, raises `coin_rej`).
- `commit`  in  1  player start/confirm, level sampled each cycle.
- `cancel`  in  1  player refund request, level sampled each cycle.
- `money`  out  10  committed amount; valid only while `set`=1, otherwise 0.
- `set`  out  1  one-cycle commit strobe to the credit counter.
- `refund`  out  10  refunded amount; valid only while `refund_vld`=1, otherwise 0.
- `refund_vld`  out  1  one-cycle refund strobe.
- `pending`  out  10  current accumulated, uncommitted amount.
- `coin_rej`  out  1  one-cycle pulse: coin rejected (invalid type or overflow).

## Operation
- States: IDLE (pending=0), COLLECT (pending>0), COMMIT (output cycle), REFUND (output cycle).
- Per-cycle effective total T = pending + value of accepted coin in that cycle (0 if none).
- Coin acceptance: valid type and pending+value ≤ 1023; otherwise coin dropped, `pending` unchanged, `coin_rej`=1 the next cycle.
- Priority: cancel > commit > timeout. Coin in the same cycle as commit/cancel is included in T.
- IDLE: accepted coin → COLLECT. commit/cancel with T=0 are ignored.
- COLLECT: cancel → REFUND with refund=T; commit → COMMIT with money=T; timeout expiry → COMMIT with money=T; otherwise stay.
- COMMIT / REFUND: strobe outputs asserted for exactly this cycle; `pending` reads 0; commit/cancel ignored; an accepted coin starts a new pending → COLLECT, else → IDLE.
- Arithmetic: all amounts unsigned 10-bit; no wrap ever occurs (overflow rejection guarantees it).
- `set` and `refund_vld` are never high in the same cycle.

## Timing
- Reset values: `money`=0, `set`=0, `refund`=0, `refund_vld`=0, `pending`=0, `coin_rej`=0, state IDLE, idle timer 0.
- All outputs registered. `pending` updates the cycle after the coin. `set`/`refund_vld` assert the cycle after commit/cancel is sampled.
- Idle timer: cleared on entry to COLLECT and on every accepted coin. Increments each COLLECT cycle otherwise. Expiry when it reaches TIMEOUT_CYC-1.
- Commit held high for several cycles: produces one `set` only. A later commit requires a new nonzero pending amount.
- Reset mid-operation: pending amount discarded; no refund or set pulse is issued.

## Configuration
- `COIN_AUTO_COMMIT_EN`: when defined, the idle timer and timeout commit are built as specified.
- When not defined, the timer is absent and `TIMEOUT_CYC` is unused. COLLECT is left only by commit or cancel, and pending is held indefinitely.

## Structure
- Shared package `game_pkg`: coin-type encodings and values (1/5/10), `AMT_W`=10, `AMT_MAX`=1023, and the state enum typedef `coin_state_t`.
- One sub-module: `idle_timer`, a clear/enable/expire counter parameterized by TIMEOUT_CYC. It is instantiated only under `COIN_AUTO_COMMIT_EN`.

## Test plan
- Coins 5, 10, 1 on separate cycles, then commit → `pending` steps 5/15/16; the cycle after commit has `set`=1, `money`=16; the following cycle has `pending`=0.
- Coin 10 then cancel with commit held in the same cycle → `refund_vld`=1, `refund`=10; `set` stays 0.
- Pending=1020, coin 5 → `coin_rej` pulse and `pending` stays 1020. Then coin 1 → `pending`=1021.
- Coin type 11 in IDLE → `coin_rej`=1 and state stays IDLE. Then commit → no `set`.
- Auto-commit (`COIN_AUTO_COMMIT_EN`, TIMEOUT_CYC=8): coin 5, then no activity → `set` with `money`=5 exactly 8 cycles after `pending` becomes 5. With the macro undefined, no `set` occurs over 100 cycles.
- Coin 10 then `rst_n` low for 1 cycle → all outputs 0 with no strobe. Then coin 1 and commit → `money`=1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the credit-intake path.
//   - Coin-type encodings and coin values (1 / 5 / 10).
//   - Amount width AMT_W and ceiling AMT_MAX.
//   - coin_state_t: coin_collector FSM states.
//   - coin_value(): coin type to amount (0 for the invalid code).
package game_pkg;

  localparam int unsigned AMT_W   = 10;
  localparam int unsigned AMT_MAX = 1023;

  typedef logic [AMT_W-1:0] amt_t;

  localparam logic [1:0] COIN_T1   = 2'b00;
  localparam logic [1:0] COIN_T5   = 2'b01;
  localparam logic [1:0] COIN_T10  = 2'b10;
  localparam logic [1:0] COIN_TBAD = 2'b11;

  localparam amt_t COIN_V1  = 10'd1;
  localparam amt_t COIN_V5  = 10'd5;
  localparam amt_t COIN_V10 = 10'd10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2,
    ST_REFUND  = 2'd3
  } coin_state_t;

  function automatic amt_t coin_value(input logic [1:0] ctype);
    amt_t v;
    v = '0;
    case (ctype)
      COIN_T1:  v = COIN_V1;
      COIN_T5:  v = COIN_V5;
      COIN_T10: v = COIN_V10;
      default:  v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/idle_timer.sv
// idle_timer: clear / enable / expire counter for the auto-commit timeout.
//   Parameter TIMEOUT_CYC (2..65535): o_expire is high while the count
//   equals TIMEOUT_CYC-1 and i_en is high.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_clr    in   synchronous clear (wins over i_en)
//   i_en     in   count enable
//   o_expire out  expiry indication (combinational from count)
module idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_cnt;

  // Saturates at CNT_LAST so the count never wraps if expiry is not acted on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_LAST)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_expire = i_en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/coin_collector.sv
// coin_collector: credit-intake stage ahead of the game credit counter.
//   Accumulates coin events into a pending amount and delivers it as a
//   one-cycle money/set pair on commit (or auto-commit timeout), or as a
//   one-cycle refund/refund_vld pair on cancel. All outputs registered.
// Configuration macro: COIN_AUTO_COMMIT_EN
//   defined   -> idle_timer built; TIMEOUT_CYC idle cycles in COLLECT commit.
//   undefined -> no timer; COLLECT left only by commit or cancel.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   coin_vld    in   one-cycle coin event
//   coin_type   in   [1:0] 00=1, 01=5, 10=10, 11=invalid
//   commit      in   player confirm (level)
//   cancel      in   player refund request (level)
//   money       out  [9:0] committed amount, nonzero only with set
//   set         out  one-cycle commit strobe
//   refund      out  [9:0] refunded amount, nonzero only with refund_vld
//   refund_vld  out  one-cycle refund strobe
//   pending     out  [9:0] accumulated uncommitted amount
//   coin_rej    out  one-cycle coin-rejected pulse
module coin_collector
  import game_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_vld,
  input  logic [1:0] coin_type,
  input  logic       commit,
  input  logic       cancel,
  output logic [9:0] money,
  output logic       set,
  output logic [9:0] refund,
  output logic       refund_vld,
  output logic [9:0] pending,
  output logic       coin_rej
);

  coin_state_t r_state;
  coin_state_t w_next;

  amt_t        r_pending;
  amt_t        r_money;
  amt_t        r_refund;
  logic        r_set;
  logic        r_refund_vld;
  logic        r_coin_rej;

  amt_t        w_coin_val;
  logic [AMT_W:0] w_sum;
  logic        w_coin_ok;
  amt_t        w_total;
  logic        w_timeout;

  amt_t        w_pending_nxt;
  amt_t        w_money_nxt;
  amt_t        w_refund_nxt;
  logic        w_set_nxt;
  logic        w_refund_vld_nxt;
  logic        w_coin_rej_nxt;

  // Coin acceptance: one extra sum bit flags a total above AMT_MAX.
  assign w_coin_val = coin_value(coin_type);
  assign w_sum      = {1'b0, r_pending} + {1'b0, w_coin_val};
  assign w_coin_ok  = coin_vld && (coin_type != COIN_TBAD) && !w_sum[AMT_W];
  assign w_total    = w_coin_ok ? w_sum[AMT_W-1:0] : r_pending;

`ifdef COIN_AUTO_COMMIT_EN
  logic w_expire;

  // Holding the timer clear outside COLLECT gives a zero count on entry.
  idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_coin_ok || (r_state != ST_COLLECT)),
    .i_en     (r_state == ST_COLLECT),
    .o_expire (w_expire)
  );

  // A coin arriving on the expiry cycle restarts the idle period.
  assign w_timeout = w_expire && !w_coin_ok;
`else
  logic w_unused_timeout_cyc;
  assign w_unused_timeout_cyc = |TIMEOUT_CYC;
  assign w_timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. In IDLE the total is nonzero only with an accepted
  // coin, so commit/cancel with nothing to deliver fall through to IDLE.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (w_total != '0) begin
          if (cancel) begin
            w_next = ST_REFUND;
          end else if (commit || w_timeout) begin
            w_next = ST_COMMIT;
          end else begin
            w_next = ST_COLLECT;
          end
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_COMMIT, ST_REFUND: begin
        w_next = w_coin_ok ? ST_COLLECT : ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Output logic: values registered alongside the state they belong to.
  always_comb begin
    w_set_nxt        = (w_next == ST_COMMIT);
    w_refund_vld_nxt = (w_next == ST_REFUND);
    w_money_nxt      = w_set_nxt        ? w_total : '0;
    w_refund_nxt     = w_refund_vld_nxt ? w_total : '0;
    w_pending_nxt    = (w_next == ST_COLLECT) ? w_total : '0;
    w_coin_rej_nxt   = coin_vld && !w_coin_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending    <= '0;
      r_money      <= '0;
      r_refund     <= '0;
      r_set        <= 1'b0;
      r_refund_vld <= 1'b0;
      r_coin_rej   <= 1'b0;
    end else begin
      r_pending    <= w_pending_nxt;
      r_money      <= w_money_nxt;
      r_refund     <= w_refund_nxt;
      r_set        <= w_set_nxt;
      r_refund_vld <= w_refund_vld_nxt;
      r_coin_rej   <= w_coin_rej_nxt;
    end
  end

  assign money      = r_money;
  assign set        = r_set;
  assign refund     = r_refund;
  assign refund_vld = r_refund_vld;
  assign pending    = r_pending;
  assign coin_rej   = r_coin_rej;

endmodule

// File: tb/tb_coin_collector.sv
// tb_coin_collector: self-checking bench for coin_collector.
//   Each driven cycle pushes the expected registered outputs (from a
//   behavioural model) into a scoreboard queue; they are popped and
//   compared one clock later. Directed scenarios add constant checks.
//   Build with or without COIN_AUTO_COMMIT_EN; TIMEOUT_CYC is set to 8.
module tb_coin_collector;

  localparam int TO = 8;

  logic       clk;
  logic       rst_n;
  logic       coin_vld;
  logic [1:0] coin_type;
  logic       commit;
  logic       cancel;
  logic [9:0] money;
  logic       set;
  logic [9:0] refund;
  logic       refund_vld;
  logic [9:0] pending;
  logic       coin_rej;

  coin_collector #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin_vld   (coin_vld),
    .coin_type  (coin_type),
    .commit     (commit),
    .cancel     (cancel),
    .money      (money),
    .set        (set),
    .refund     (refund),
    .refund_vld (refund_vld),
    .pending    (pending),
    .coin_rej   (coin_rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int money;
    int set;
    int refund;
    int refund_vld;
    int pending;
    int coin_rej;
  } exp_t;

  exp_t sb_q[$];

  int n_chk = 0;
  int n_err = 0;

  // Model state: 0 = IDLE, 1 = COLLECT, 2 = COMMIT/REFUND output cycle
  int m_st  = 0;
  int m_pnd = 0;
  int m_tmr = 0;

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st  = 0;
    m_pnd = 0;
    m_tmr = 0;
  endtask

  // Drive one cycle of inputs, predict, then compare one clock later.
  task automatic cyc(input logic v, input logic [1:0] t,
                     input logic cm, input logic cn);
    exp_t e;
    exp_t g;
    int   val;
    bit   ok;
    int   tot;
    bit   tmo;
    int   nst;

    @(negedge clk);
    coin_vld  = v;
    coin_type = t;
    commit    = cm;
    cancel    = cn;

    case (t)
      2'b00:   val = 1;
      2'b01:   val = 5;
      2'b10:   val = 10;
      default: val = 0;
    endcase
    ok  = v && (t != 2'b11) && (m_pnd + val <= 1023);
    tot = m_pnd + (ok ? val : 0);
`ifdef COIN_AUTO_COMMIT_EN
    tmo = (m_st == 1) && (m_tmr == TO - 1) && !ok;
`else
    tmo = 1'b0;
`endif
    e = '{money: 0, set: 0, refund: 0, refund_vld: 0, pending: 0,
          coin_rej: (v && !ok) ? 1 : 0};
    if (m_st != 2 && tot != 0 && cn) begin
      e.refund = tot; e.refund_vld = 1; nst = 2;
    end else if (m_st != 2 && tot != 0 && (cm || tmo)) begin
      e.money = tot; e.set = 1; nst = 2;
    end else if (tot != 0) begin
      e.pending = tot; nst = 1;
    end else begin
      nst = 0;
    end
    if (nst == 1) m_tmr = (m_st != 1 || ok) ? 0 : m_tmr + 1;
    m_st  = nst;
    m_pnd = e.pending;
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      g = sb_q.pop_front();
      check("money",      int'(money),      g.money);
      check("set",        int'(set),        g.set);
      check("refund",     int'(refund),     g.refund);
      check("refund_vld", int'(refund_vld), g.refund_vld);
      check("pending",    int'(pending),    g.pending);
      check("coin_rej",   int'(coin_rej),   g.coin_rej);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b0;
    coin_vld = 1'b0;
    commit   = 1'b0;
    cancel   = 1'b0;
    #1;
    check({tag, "_money"},   int'(money),      0);
    check({tag, "_set"},     int'(set),        0);
    check({tag, "_refund"},  int'(refund),     0);
    check({tag, "_rvld"},    int'(refund_vld), 0);
    check({tag, "_pending"}, int'(pending),    0);
    check({tag, "_rej"},     int'(coin_rej),   0);
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int first_set;
    int n_set;

    rst_n     = 1'b0;
    coin_vld  = 1'b0;
    coin_type = 2'b00;
    commit    = 1'b0;
    cancel    = 1'b0;
    do_reset("rst");

    // Coins 5, 10, 1 then commit
    cyc(1, 2'b01, 0, 0); check("t1_p5",  int'(pending), 5);
    cyc(1, 2'b10, 0, 0); check("t1_p15", int'(pending), 15);
    cyc(1, 2'b00, 0, 0); check("t1_p16", int'(pending), 16);
    cyc(0, 2'b00, 1, 0); check("t1_set", int'(set), 1);
    check("t1_money", int'(money), 16);
    cyc(0, 2'b00, 0, 0); check("t1_p0", int'(pending), 0);

    // Coin 10, then cancel with commit held in the same cycle
    cyc(1, 2'b10, 0, 0);
    cyc(0, 2'b00, 1, 1); check("t2_rvld", int'(refund_vld), 1);
    check("t2_refund", int'(refund), 10);
    check("t2_noset", int'(set), 0);
    cyc(0, 2'b00, 0, 0);

    // Overflow: build 1020, reject 5, accept 1
    for (int i = 0; i < 102; i++) cyc(1, 2'b10, 0, 0);
    check("t3_p1020", int'(pending), 1020);
    cyc(1, 2'b01, 0, 0); check("t3_rej", int'(coin_rej), 1);
    check("t3_hold", int'(pending), 1020);
    cyc(1, 2'b00, 0, 0); check("t3_p1021", int'(pending), 1021);
    check("t3_norej", int'(coin_rej), 0);
    cyc(0, 2'b00, 0, 1); check("t3_refund", int'(refund), 1021);
    cyc(0, 2'b00, 0, 0);

    // Invalid coin in IDLE, then commit with nothing pending
    cyc(1, 2'b11, 0, 0); check("t4_rej", int'(coin_rej), 1);
    check("t4_p0", int'(pending), 0);
    cyc(0, 2'b00, 1, 0); check("t4_noset", int'(set), 0);
    cyc(0, 2'b00, 0, 0);

    // Commit held for several cycles gives a single set
    cyc(1, 2'b01, 0, 0);
    n_set = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 2'b00, 1, 0);
      if (set) n_set++;
    end
    check("hold_one_set", n_set, 1);
    cyc(0, 2'b00, 0, 0);

    // Auto-commit timeout
    cyc(1, 2'b01, 0, 0); check("t5_p5", int'(pending), 5);
    first_set = -1;
    for (int i = 1; i <= 100; i++) begin
      cyc(0, 2'b00, 0, 0);
      if (set && first_set < 0) first_set = i;
    end
`ifdef COIN_AUTO_COMMIT_EN
    check("t5_latency", first_set, 8);
`else
    check("t5_noset", first_set, -1);
    check("t5_held", int'(pending), 5);
    cyc(0, 2'b00, 0, 1);
`endif
    cyc(0, 2'b00, 0, 0);

    // Reset mid-operation discards pending without a strobe
    cyc(1, 2'b10, 0, 0);
    do_reset("t6");
    cyc(1, 2'b00, 0, 0); check("t6_p1", int'(pending), 1);
    cyc(0, 2'b00, 1, 0); check("t6_set", int'(set), 1);
    check("t6_money", int'(money), 1);
    cyc(0, 2'b00, 0, 0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0));
    end

    // Coin together with commit in IDLE delivers immediately
    cyc(0, 2'b00, 0, 1);
    cyc(0, 2'b00, 0, 0);
    cyc(1, 2'b10, 1, 0); check("t7_set", int'(set), 1);
    check("t7_money", int'(money), 10);
    cyc(0, 2'b00, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
